// File: rtl/if_id_stage_ctrl_pkg.sv
// Shared definitions for the IF/ID front-end controller.
//   fe_state encodings and the layout of the fetched VLIW bundle
//   {instr_32, instr_16}.
package if_id_stage_ctrl_pkg;

  // Front-end state encodings (value of the fe_state output)
  localparam logic [1:0] FE_RUN     = 2'b00;
  localparam logic [1:0] FE_STALL   = 2'b01;
  localparam logic [1:0] FE_FLUSHED = 2'b10;

  // Bundle split: 16-bit slot in the low bits, 32-bit slot above it
  localparam int unsigned INSTR16_W   = 16;
  localparam int unsigned INSTR32_W   = 32;
  localparam int unsigned INSTR16_LSB = 0;
  localparam int unsigned INSTR32_LSB = INSTR16_LSB + INSTR16_W;

  typedef struct packed {
    logic [INSTR32_W-1:0] instr_32;
    logic [INSTR16_W-1:0] instr_16;
  } bundle_t;

endpackage

// File: rtl/if_id_stage_ctrl_if.sv
// Hazard/fetch bus of the IF/ID controller.
//   master: hazard units, imem and observers (drive requests, read state)
//   slave : if_id_stage_ctrl (consumes requests, drives PC/IF/ID/counters)
interface if_id_stage_ctrl_if #(
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned INSTR_WIDTH = 48,
  parameter int unsigned CNT_WIDTH   = 16
);
  // Load-use hazard unit
  logic                   pc_write_lu;
  logic                   ifid_write_lu;
  logic                   flush_ctrl_lu;
  // Branch-data hazard unit
  logic                   pc_write_bd;
  logic                   ifid_write_bd;
  logic                   flush_ctrl_bd;
  // Branch-control hazard unit
  logic                   branch_pc_src;
  logic                   jump_pc_src;
  logic                   ifid_flush;
  logic [PC_WIDTH-1:0]    branch_target;
  logic [PC_WIDTH-1:0]    jump_target;
  // Instruction memory and counter control
  logic [INSTR_WIDTH-1:0] imem_instr;
  logic                   counters_clr;
  // Controller outputs
  logic [PC_WIDTH-1:0]    pc;
  logic [PC_WIDTH-1:0]    ifid_pc;
  logic [INSTR_WIDTH-1:0] ifid_instr;
  logic                   ifid_valid;
  logic                   idex_bubble;
  logic [1:0]             fe_state;
  logic [CNT_WIDTH-1:0]   stall_cycles;
  logic [CNT_WIDTH-1:0]   flush_count;
  logic                   stall_timeout;

  modport master (
    output pc_write_lu, ifid_write_lu, flush_ctrl_lu,
    output pc_write_bd, ifid_write_bd, flush_ctrl_bd,
    output branch_pc_src, jump_pc_src, ifid_flush,
    output branch_target, jump_target, imem_instr, counters_clr,
    input  pc, ifid_pc, ifid_instr, ifid_valid, idex_bubble,
    input  fe_state, stall_cycles, flush_count, stall_timeout
  );

  modport slave (
    input  pc_write_lu, ifid_write_lu, flush_ctrl_lu,
    input  pc_write_bd, ifid_write_bd, flush_ctrl_bd,
    input  branch_pc_src, jump_pc_src, ifid_flush,
    input  branch_target, jump_target, imem_instr, counters_clr,
    output pc, ifid_pc, ifid_instr, ifid_valid, idex_bubble,
    output fe_state, stall_cycles, flush_count, stall_timeout
  );
endinterface

// File: rtl/if_id_stage_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
//   clk, rst : clock, asynchronous active-high reset
//   inc      : count this cycle (ignored once all-ones)
//   clr      : synchronous clear
//   count    : registered count value
module if_id_stage_ctrl_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/if_id_stage_ctrl.sv
// Front-end pipeline controller: merges load-use, branch-data and
// branch-control hazard requests and applies hold / redirect / bubble
// actions to the PC and IF/ID registers; keeps stall/flush counters and
// a sticky consecutive-stall watchdog.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : slave side of if_id_stage_ctrl_if (hazard requests, redirect
//           targets, imem data, counters_clr in; pc, IF/ID bundle,
//           idex_bubble, fe_state, counters, stall_timeout out)
module if_id_stage_ctrl
  import if_id_stage_ctrl_pkg::*;
#(
  parameter int unsigned         PC_WIDTH    = 32,
  parameter int unsigned         INSTR_WIDTH = 48,
  parameter int unsigned         PC_INC      = 1,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned         CNT_WIDTH   = 16,
  parameter int unsigned         MAX_STALL   = 8
) (
  input logic              clk,
  input logic              reset,
  if_id_stage_ctrl_if.slave bus
);

  localparam int unsigned RUN_W = $clog2(MAX_STALL + 1);

  logic                   stall_c;
  logic                   redirect_req_c;
  logic                   redirect_c;
  logic [PC_WIDTH-1:0]    pc_q;
  logic [PC_WIDTH-1:0]    pc_d;
  logic [PC_WIDTH-1:0]    ifid_pc_q;
  logic [INSTR_WIDTH-1:0] ifid_instr_q;
  logic                   ifid_valid_q;
  logic [1:0]             state_q;
  logic [1:0]             state_d;
  logic [RUN_W-1:0]       stall_run_q;
  logic                   stall_timeout_q;

  // Hazard merge; a stall masks any redirect so the branch stays in ID
  assign stall_c        = ~bus.pc_write_lu | ~bus.ifid_write_lu |
                          ~bus.pc_write_bd | ~bus.ifid_write_bd;
  assign redirect_req_c = bus.jump_pc_src | bus.branch_pc_src | bus.ifid_flush;
  assign redirect_c     = ~stall_c & redirect_req_c;

  assign bus.idex_bubble = bus.flush_ctrl_lu | bus.flush_ctrl_bd;

  // Next PC: hold, jump, branch, sequential (wraps naturally)
  always_comb begin
    pc_d = pc_q + PC_WIDTH'(PC_INC);
    if (stall_c) begin
      pc_d = pc_q;
    end else if (bus.jump_pc_src) begin
      pc_d = bus.jump_target;
    end else if (bus.branch_pc_src) begin
      pc_d = bus.branch_target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // IF/ID bundle register: hold, bubble on redirect, or capture fetch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid_pc_q    <= '0;
      ifid_instr_q <= '0;
      ifid_valid_q <= 1'b0;
    end else if (stall_c) begin
      ifid_pc_q    <= ifid_pc_q;
      ifid_instr_q <= ifid_instr_q;
      ifid_valid_q <= ifid_valid_q;
    end else if (redirect_c) begin
      ifid_pc_q    <= '0;
      ifid_instr_q <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      ifid_pc_q    <= pc_q;
      ifid_instr_q <= bus.imem_instr;
      ifid_valid_q <= 1'b1;
    end
  end

  // Front-end state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FE_FLUSHED;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state depends only on this cycle's requests, from any state
  always_comb begin
    state_d = FE_RUN;
    if (stall_c) begin
      state_d = FE_STALL;
    end else if (redirect_c) begin
      state_d = FE_FLUSHED;
    end
  end

  // Performance counters
  if_id_stage_ctrl_sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst   (reset),
    .inc   (stall_c),
    .clr   (bus.counters_clr),
    .count (bus.stall_cycles)
  );

  if_id_stage_ctrl_sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst   (reset),
    .inc   (redirect_c),
    .clr   (bus.counters_clr),
    .count (bus.flush_count)
  );

  // Watchdog: run length stops at MAX_STALL; flag trips on the edge that
  // completes the MAX_STALL-th consecutive stall cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_run_q     <= '0;
      stall_timeout_q <= 1'b0;
    end else if (bus.counters_clr) begin
      stall_run_q     <= '0;
      stall_timeout_q <= 1'b0;
    end else if (stall_c) begin
      if (stall_run_q != RUN_W'(MAX_STALL)) begin
        stall_run_q <= stall_run_q + RUN_W'(1);
      end
      if (stall_run_q >= RUN_W'(MAX_STALL - 1)) begin
        stall_timeout_q <= 1'b1;
      end
    end else begin
      stall_run_q <= '0;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.ifid_pc       = ifid_pc_q;
  assign bus.ifid_instr    = ifid_instr_q;
  assign bus.ifid_valid    = ifid_valid_q;
  assign bus.fe_state      = state_q;
  assign bus.stall_timeout = stall_timeout_q;

endmodule
